// File: rtl/micro_tlb.sv
// +------------------------------------------------------------------------------+
// | micro_tlb : fully associative instruction-fetch micro-TLB in front of one     |
// |             mmu search port. Optional: MICRO_TLB_PERF_EN adds hit/miss counts |
// | Revision  : 1.0                                                               |
// +------------------------------------------------------------------------------+
`default_nettype none

module micro_tlb #(
  parameter int ENTRY_NUM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [31:0] req_vaddr_i,
  input  logic        req_dmw0_en_i,
  input  logic        req_dmw1_en_i,
  input  logic        req_trans_en_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_paddr_o,
  output logic [1:0]  resp_mat_o,
  output logic        resp_found_o,
  output logic        resp_v_o,
  output logic        resp_d_o,
  output logic [1:0]  resp_plv_o,
  output logic        resp_hit_o,
  output logic [31:0] mmu_vaddr_o,
  output logic        mmu_dmw0_en_o,
  output logic        mmu_dmw1_en_o,
  output logic        mmu_trans_en_o,
  input  logic [31:0] mmu_paddr_i,
  input  logic [1:0]  mmu_mat_i,
  input  logic [1:0]  mmu_plv_i,
  input  logic        mmu_found_i,
  input  logic        mmu_v_i,
  input  logic        mmu_d_i,
`ifdef MICRO_TLB_PERF_EN
  output logic [31:0] perf_hit_cnt_o,
  output logic [31:0] perf_miss_cnt_o,
`endif
  input  logic        flush_i
);

  localparam int PTR_W = $clog2(ENTRY_NUM);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [19:0]          tag_q   [ENTRY_NUM];
  logic [19:0]          tag_d   [ENTRY_NUM];
  logic [19:0]          ppn_q   [ENTRY_NUM];
  logic [19:0]          ppn_d   [ENTRY_NUM];
  logic [1:0]           mat_q   [ENTRY_NUM];
  logic [1:0]           mat_d   [ENTRY_NUM];
  logic [1:0]           plv_q   [ENTRY_NUM];
  logic [1:0]           plv_d   [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] found_q, found_d;
  logic [ENTRY_NUM-1:0] v_q, v_d;
  logic [ENTRY_NUM-1:0] d_q, d_d;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             flush_pend_q, flush_pend_d;

  logic [31:0] lat_vaddr_q, lat_vaddr_d;
  logic        lat_dmw0_q, lat_dmw0_d;
  logic        lat_dmw1_q, lat_dmw1_d;
  logic        lat_trans_q, lat_trans_d;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_paddr_q, resp_paddr_d;
  logic [1:0]  resp_mat_q, resp_mat_d;
  logic [1:0]  resp_plv_q, resp_plv_d;
  logic        resp_found_q, resp_found_d;
  logic        resp_v_q, resp_v_d;
  logic        resp_d_q, resp_d_d;
  logic        resp_hit_q, resp_hit_d;

`ifdef MICRO_TLB_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
`endif

  logic [ENTRY_NUM-1:0] hit_vec;
  logic                 any_hit;
  logic                 accept;
  logic                 serve_hit;
  logic [19:0]          sel_ppn;
  logic [1:0]           sel_mat;
  logic [1:0]           sel_plv;
  logic                 sel_found;
  logic                 sel_v;
  logic                 sel_d;
  logic [PTR_W-1:0]     inv_idx;
  logic                 any_inv;
  logic [PTR_W-1:0]     victim;

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_cmp
    assign hit_vec[i] = valid_q[i] && (tag_q[i] == req_vaddr_i[31:12]);
  end

  assign any_hit   = |hit_vec;
  assign accept    = req_valid_i && (state_q == IDLE);
  // A flush in the accept cycle invalidates the entry being hit, so force a miss.
  assign serve_hit = any_hit && !flush_i;

  // Tags are unique, so an OR over the one-hot hit vector selects the entry.
  always_comb begin
    sel_ppn   = '0;
    sel_mat   = '0;
    sel_plv   = '0;
    sel_found = 1'b0;
    sel_v     = 1'b0;
    sel_d     = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (hit_vec[i]) begin
        sel_ppn   = sel_ppn | ppn_q[i];
        sel_mat   = sel_mat | mat_q[i];
        sel_plv   = sel_plv | plv_q[i];
        sel_found = sel_found | found_q[i];
        sel_v     = sel_v | v_q[i];
        sel_d     = sel_d | d_q[i];
      end
    end
  end

  always_comb begin
    inv_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) inv_idx = PTR_W'(i);
    end
  end

  assign any_inv = ~&valid_q;
  assign victim  = any_inv ? inv_idx : ptr_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    ppn_d        = ppn_q;
    mat_d        = mat_q;
    plv_d        = plv_q;
    found_d      = found_q;
    v_d          = v_q;
    d_d          = d_q;
    ptr_d        = ptr_q;
    flush_pend_d = flush_pend_q;
    lat_vaddr_d  = lat_vaddr_q;
    lat_dmw0_d   = lat_dmw0_q;
    lat_dmw1_d   = lat_dmw1_q;
    lat_trans_d  = lat_trans_q;
    resp_valid_d = 1'b0;
    resp_paddr_d = resp_paddr_q;
    resp_mat_d   = resp_mat_q;
    resp_plv_d   = resp_plv_q;
    resp_found_d = resp_found_q;
    resp_v_d     = resp_v_q;
    resp_d_d     = resp_d_q;
    resp_hit_d   = resp_hit_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (serve_hit) begin
            resp_valid_d = 1'b1;
            resp_paddr_d = {sel_ppn, req_vaddr_i[11:0]};
            resp_mat_d   = sel_mat;
            resp_plv_d   = sel_plv;
            resp_found_d = sel_found;
            resp_v_d     = sel_v;
            resp_d_d     = sel_d;
            resp_hit_d   = 1'b1;
          end else begin
            lat_vaddr_d  = req_vaddr_i;
            lat_dmw0_d   = req_dmw0_en_i;
            lat_dmw1_d   = req_dmw1_en_i;
            lat_trans_d  = req_trans_en_i;
            flush_pend_d = flush_i;
            state_d      = MISS;
          end
        end
      end
      MISS: begin
        resp_valid_d = 1'b1;
        resp_paddr_d = mmu_paddr_i;
        resp_mat_d   = mmu_mat_i;
        resp_plv_d   = mmu_plv_i;
        resp_found_d = mmu_found_i;
        resp_v_d     = mmu_v_i;
        resp_d_d     = mmu_d_i;
        resp_hit_d   = 1'b0;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
        // A result looked up under a stale context must not be cached.
        if (!flush_pend_q && !flush_i) begin
          valid_d[victim] = 1'b1;
          tag_d[victim]   = lat_vaddr_q[31:12];
          ppn_d[victim]   = mmu_paddr_i[31:12];
          mat_d[victim]   = mmu_mat_i;
          plv_d[victim]   = mmu_plv_i;
          found_d[victim] = mmu_found_i;
          v_d[victim]     = mmu_v_i;
          d_d[victim]     = mmu_d_i;
          if (!any_inv) ptr_d = ptr_q + PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) valid_d = '0;
  end

`ifdef MICRO_TLB_PERF_EN
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept && serve_hit)  hit_cnt_d  = hit_cnt_q + 32'd1;
    if (accept && !serve_hit) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt_o  = hit_cnt_q;
  assign perf_miss_cnt_o = miss_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      ptr_q        <= '0;
      flush_pend_q <= 1'b0;
      lat_vaddr_q  <= '0;
      lat_dmw0_q   <= 1'b0;
      lat_dmw1_q   <= 1'b0;
      lat_trans_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_paddr_q <= '0;
      resp_mat_q   <= '0;
      resp_plv_q   <= '0;
      resp_found_q <= 1'b0;
      resp_v_q     <= 1'b0;
      resp_d_q     <= 1'b0;
      resp_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
      flush_pend_q <= flush_pend_d;
      lat_vaddr_q  <= lat_vaddr_d;
      lat_dmw0_q   <= lat_dmw0_d;
      lat_dmw1_q   <= lat_dmw1_d;
      lat_trans_q  <= lat_trans_d;
      resp_valid_q <= resp_valid_d;
      resp_paddr_q <= resp_paddr_d;
      resp_mat_q   <= resp_mat_d;
      resp_plv_q   <= resp_plv_d;
      resp_found_q <= resp_found_d;
      resp_v_q     <= resp_v_d;
      resp_d_q     <= resp_d_d;
      resp_hit_q   <= resp_hit_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    ppn_q   <= ppn_d;
    mat_q   <= mat_d;
    plv_q   <= plv_d;
    found_q <= found_d;
    v_q     <= v_d;
    d_q     <= d_d;
  end

  assign req_ready_o    = (state_q == IDLE);
  assign resp_valid_o   = resp_valid_q;
  assign resp_paddr_o   = resp_paddr_q;
  assign resp_mat_o     = resp_mat_q;
  assign resp_plv_o     = resp_plv_q;
  assign resp_found_o   = resp_found_q;
  assign resp_v_o       = resp_v_q;
  assign resp_d_o       = resp_d_q;
  assign resp_hit_o     = resp_hit_q;
  assign mmu_vaddr_o    = lat_vaddr_q;
  assign mmu_dmw0_en_o  = lat_dmw0_q;
  assign mmu_dmw1_en_o  = lat_dmw1_q;
  assign mmu_trans_en_o = lat_trans_q;

endmodule

`default_nettype wire

// File: tb/tb_micro_tlb.sv
// +------------------------------------------------------------------------------+
// | tb_micro_tlb : directed self-checking bench for micro_tlb (ENTRY_NUM = 4)     |
// | Revision     : 1.0                                                            |
// +------------------------------------------------------------------------------+
`default_nettype none

module tb_micro_tlb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic [31:0] req_vaddr_i;
  logic        req_dmw0_en_i;
  logic        req_dmw1_en_i;
  logic        req_trans_en_i;
  logic        req_ready_o;
  logic        resp_valid_o;
  logic [31:0] resp_paddr_o;
  logic [1:0]  resp_mat_o;
  logic        resp_found_o;
  logic        resp_v_o;
  logic        resp_d_o;
  logic [1:0]  resp_plv_o;
  logic        resp_hit_o;
  logic [31:0] mmu_vaddr_o;
  logic        mmu_dmw0_en_o;
  logic        mmu_dmw1_en_o;
  logic        mmu_trans_en_o;
  logic [31:0] mmu_paddr_i;
  logic [1:0]  mmu_mat_i;
  logic [1:0]  mmu_plv_i;
  logic        mmu_found_i;
  logic        mmu_v_i;
  logic        mmu_d_i;
  logic        flush_i;
`ifdef MICRO_TLB_PERF_EN
  logic [31:0] perf_hit_cnt_o;
  logic [31:0] perf_miss_cnt_o;
`endif

  logic [19:0] m_ppn;
  logic        m_found;
  logic        m_v;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Stand-in mmu: page number chosen per test, offset passed through.
  assign mmu_paddr_i = {m_ppn, mmu_vaddr_o[11:0]};
  assign mmu_mat_i   = 2'd1;
  assign mmu_plv_i   = 2'd3;
  assign mmu_found_i = m_found;
  assign mmu_v_i     = m_v;
  assign mmu_d_i     = 1'b1;

  micro_tlb #(.ENTRY_NUM(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_vaddr_i    (req_vaddr_i),
    .req_dmw0_en_i  (req_dmw0_en_i),
    .req_dmw1_en_i  (req_dmw1_en_i),
    .req_trans_en_i (req_trans_en_i),
    .req_ready_o    (req_ready_o),
    .resp_valid_o   (resp_valid_o),
    .resp_paddr_o   (resp_paddr_o),
    .resp_mat_o     (resp_mat_o),
    .resp_found_o   (resp_found_o),
    .resp_v_o       (resp_v_o),
    .resp_d_o       (resp_d_o),
    .resp_plv_o     (resp_plv_o),
    .resp_hit_o     (resp_hit_o),
    .mmu_vaddr_o    (mmu_vaddr_o),
    .mmu_dmw0_en_o  (mmu_dmw0_en_o),
    .mmu_dmw1_en_o  (mmu_dmw1_en_o),
    .mmu_trans_en_o (mmu_trans_en_o),
    .mmu_paddr_i    (mmu_paddr_i),
    .mmu_mat_i      (mmu_mat_i),
    .mmu_plv_i      (mmu_plv_i),
    .mmu_found_i    (mmu_found_i),
    .mmu_v_i        (mmu_v_i),
    .mmu_d_i        (mmu_d_i),
`ifdef MICRO_TLB_PERF_EN
    .perf_hit_cnt_o (perf_hit_cnt_o),
    .perf_miss_cnt_o(perf_miss_cnt_o),
`endif
    .flush_i        (flush_i)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // One request from an idle DUT; inputs driven and outputs sampled on negedges.
  task automatic access(input string tag, input logic [31:0] va, input bit fl_acc,
                        input bit fl_miss, input bit exp_hit, input logic [31:0] exp_pa,
                        input bit exp_found, input bit exp_v);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_vaddr_i = va;
    flush_i     = fl_acc;
    @(negedge clk);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    if (!exp_hit) begin
      check({tag, "_early_valid"}, {31'd0, resp_valid_o}, 32'd0);
      check({tag, "_miss_busy"}, {31'd0, req_ready_o}, 32'd0);
      check({tag, "_mmu_vaddr"}, mmu_vaddr_o, va);
      check({tag, "_mmu_flags"}, {29'd0, mmu_dmw0_en_o, mmu_dmw1_en_o, mmu_trans_en_o}, 32'd3);
      flush_i = fl_miss;
      @(negedge clk);
      flush_i = 1'b0;
    end
    check({tag, "_valid"}, {31'd0, resp_valid_o}, 32'd1);
    check({tag, "_hit"}, {31'd0, resp_hit_o}, {31'd0, exp_hit});
    check({tag, "_paddr"}, resp_paddr_o, exp_pa);
    check({tag, "_flags"}, {28'd0, resp_found_o, resp_v_o, resp_mat_o},
          {28'd0, exp_found, exp_v, 2'd1});
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    req_valid_i    = 1'b0;
    req_vaddr_i    = '0;
    req_dmw0_en_i  = 1'b0;
    req_dmw1_en_i  = 1'b1;
    req_trans_en_i = 1'b1;
    flush_i        = 1'b0;
    m_ppn          = '0;
    m_found        = 1'b1;
    m_v            = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_valid", {31'd0, resp_valid_o}, 32'd0);
    check("rst_resp", {resp_paddr_o[31:8], resp_mat_o, resp_plv_o, resp_found_o,
                       resp_v_o, resp_d_o, resp_hit_o}, 32'd0);
    check("rst_mmu", mmu_vaddr_o | {29'd0, mmu_dmw0_en_o, mmu_dmw1_en_o, mmu_trans_en_o}, 32'd0);
`ifdef MICRO_TLB_PERF_EN
    check("rst_perf", perf_hit_cnt_o | perf_miss_cnt_o, 32'd0);
`endif
    rst_n = 1'b1;

    // Cold miss, then a hit on the same page.
    m_ppn = 20'h00000;
    access("cold", 32'h1C00_0040, 0, 0, 0, 32'h0000_0040, 1, 1);
    m_ppn = 20'hDEAD0;
    access("rehit", 32'h1C00_0FFC, 0, 0, 1, 32'h0000_0FFC, 1, 1);

    // Flush pulse forgets the page.
    flush_pulse();
    m_ppn = 20'h00077;
    access("postflush", 32'h1C00_0000, 0, 0, 0, 32'h0007_7000, 1, 1);

    // Fill entries 0..3 from empty.
    flush_pulse();
    for (int k = 1; k <= 4; k++) begin
      m_ppn = 20'h00100 + 20'(k);
      access("fill", 32'(k) << 12, 0, 0, 0, {20'h00100 + 20'(k), 12'h000}, 1, 1);
    end
    m_ppn = 20'hDEAD0;
    access("fill_hit", 32'h0000_3004, 0, 0, 1, 32'h0010_3004, 1, 1);

    // Back-to-back hits, one response per cycle.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_vaddr_i = 32'h0000_1008;
    @(negedge clk);
    check("b2b0_hit", {31'd0, resp_valid_o & resp_hit_o}, 32'd1);
    check("b2b0_paddr", resp_paddr_o, 32'h0010_1008);
    check("b2b0_ready", {31'd0, req_ready_o}, 32'd1);
    req_vaddr_i = 32'h0000_4008;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("b2b1_hit", {31'd0, resp_valid_o & resp_hit_o}, 32'd1);
    check("b2b1_paddr", resp_paddr_o, 32'h0010_4008);

    // Replacement: 0x5000 evicts entry 0, then 0x1000 evicts entry 1.
    m_ppn = 20'h00105;
    access("evict0", 32'h0000_5000, 0, 0, 0, 32'h0010_5000, 1, 1);
    m_ppn = 20'h00201;
    access("evict1", 32'h0000_1000, 0, 0, 0, 32'h0020_1000, 1, 1);
    m_ppn = 20'hDEAD0;
    access("keep3", 32'h0000_3000, 0, 0, 1, 32'h0010_3000, 1, 1);
    access("keep5", 32'h0000_5000, 0, 0, 1, 32'h0010_5000, 1, 1);
    m_ppn = 20'h00202;
    access("gone2", 32'h0000_2000, 0, 0, 0, 32'h0020_2000, 1, 1);
    m_ppn = 20'h00203;
    access("gone3", 32'h0000_3000, 0, 0, 0, 32'h0020_3000, 1, 1);

    // Flush during MISS: result returned but not cached.
    m_ppn = 20'h00306;
    access("flmiss", 32'h0000_6000, 0, 1, 0, 32'h0030_6000, 1, 1);
    m_ppn = 20'h00316;
    access("flmiss_again", 32'h0000_6000, 0, 0, 0, 32'h0031_6000, 1, 1);
    m_ppn = 20'hDEAD0;
    access("flmiss_hit", 32'h0000_6000, 0, 0, 1, 32'h0031_6000, 1, 1);

    // Flush concurrent with a hit-accept turns it into an uncached miss.
    m_ppn = 20'h00326;
    access("flacc", 32'h0000_6000, 1, 0, 0, 32'h0032_6000, 1, 1);
    m_ppn = 20'h00336;
    access("flacc_again", 32'h0000_6000, 0, 0, 0, 32'h0033_6000, 1, 1);

    // Faulting translations are cached too.
    m_found = 1'b0;
    m_v     = 1'b0;
    m_ppn   = 20'h00800;
    access("fault", 32'h8000_0000, 0, 0, 0, 32'h0080_0000, 0, 0);
    m_found = 1'b1;
    m_v     = 1'b1;
    m_ppn   = 20'hDEAD0;
    access("fault_hit", 32'h8000_0010, 0, 0, 1, 32'h0080_0010, 0, 0);

    // Reset asserted during MISS.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_vaddr_i = 32'h0000_9000;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rstmiss_busy", {31'd0, req_ready_o}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmiss_novalid", {31'd0, resp_valid_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmiss_ready", {31'd0, req_ready_o}, 32'd1);
    check("rstmiss_novalid2", {31'd0, resp_valid_o}, 32'd0);
`ifdef MICRO_TLB_PERF_EN
    check("rstmiss_perf_hit", perf_hit_cnt_o, 32'd0);
    check("rstmiss_perf_miss", perf_miss_cnt_o, 32'd0);
`endif
    m_ppn = 20'h00900;
    access("rst_inval_a", 32'h8000_0000, 0, 0, 0, 32'h0090_0000, 1, 1);
    m_ppn = 20'h00906;
    access("rst_inval_b", 32'h0000_6000, 0, 0, 0, 32'h0090_6000, 1, 1);
    m_ppn = 20'hDEAD0;
    access("rst_refill_hit", 32'h8000_0004, 0, 0, 1, 32'h0090_0004, 1, 1);
`ifdef MICRO_TLB_PERF_EN
    check("perf_hit", perf_hit_cnt_o, 32'd1);
    check("perf_miss", perf_miss_cnt_o, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/micro_tlb.md
# micro_tlb

Fully associative micro-TLB placed in front of one `mmu` search port on the instruction-fetch path. It caches complete translation results per 4 KB virtual page, covering paddr, mat and the found/v/d/plv flags. A hit is returned one cycle after request acceptance without using the `mmu` port. A miss spends one extra cycle driving the `mmu` port and installs the result. All entries are discarded on any translation-context change, signalled by `flush_i`.

## Interface
- `ENTRY_NUM`, default 4: number of entries; power of two, 2..16.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `req_valid_i`  in  1  fetch translation request
- `req_vaddr_i`  in  32  virtual address
- `req_dmw0_en_i` / `req_dmw1_en_i` / `req_trans_en_i`  in  1 each  mode flags, forwarded to the `mmu` on a miss
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o`
- `resp_valid_o`  out  1  one-cycle result pulse; no backpressure
- `resp_paddr_o`  out  32  physical address
- `resp_mat_o`  out  2  memory access type
- `resp_found_o`, `resp_v_o`, `resp_d_o`  out  1 each  flags for the exception logic
- `resp_plv_o`  out  2  page privilege
- `resp_hit_o`  out  1  result was served from the micro-TLB
- `mmu_vaddr_o`  out  32  `mmu` search request
- `mmu_dmw0_en_o`, `mmu_dmw1_en_o`, `mmu_trans_en_o`  out  1 each  `mmu` request flags
- `mmu_paddr_i`  in  32  `mmu` result, combinational, same cycle
- `mmu_mat_i`  in  2  `mmu` result
- `mmu_plv_i`  in  2  `mmu` result
- `mmu_found_i`, `mmu_v_i`, `mmu_d_i`  in  1 each  `mmu` result
- `flush_i`  in  1  invalidate all entries (tlbwr, tlbfill, invtlb, writes to ASID/CRMD/DMW0/DMW1)

## Operation
- **Entry contents:** valid, tag `vaddr[31:12]`, `ppn[31:12]`, mat, found, v, d, plv.
- **States:** IDLE and MISS. Reset enters IDLE.
- **IDLE:**
  - `req_ready_o` = 1.
  - On acceptance, the request is compared against all valid tags in parallel.
  - Hit, with `flush_i` = 0: register the response, `paddr = {ppn, vaddr[11:0]}`, `resp_hit_o` = 1. Stay in IDLE.
  - Miss, or `flush_i` = 1 in the accept cycle: latch vaddr and the mode flags, go to MISS.
- **MISS:**
  - `req_ready_o` = 0.
  - `mmu_*_o` are driven from the latched request.
  - At the clock edge, register the `mmu` result into the response regs with `resp_hit_o` = 0, install it into an entry, and return to IDLE.
- **`mmu_*_o` outside MISS:** the latched request values; they are don't-care for the `mmu`.
- **Install target:** the lowest-index invalid entry. If none is invalid, use the entry at the round-robin pointer.
- **Round-robin pointer:** reset value 0. It increments modulo ENTRY_NUM only when the install uses the pointer slot.
- **Flush:**
  - `flush_i` clears every valid bit at the next edge.
  - If `flush_i` is asserted during MISS (same cycle or earlier in that miss), the result is still returned but is not installed.
  - The flush-pending flag clears on return to IDLE.
- **Results are cached unconditionally,** including not-found and invalid entries. This is safe because every context change flushes.
- **Duplicate tags:** cannot occur, since there is only one outstanding miss and a hit never installs.

## Timing
- **Reset values:**
  - all valid bits 0, pointer 0, state IDLE
  - `resp_valid_o` 0 and all `resp_*` 0
  - `mmu_*_o` 0, `req_ready_o` 1
- **Hit:** accept at cycle N, `resp_valid_o` at N+1.
- **Miss:** accept at N, `mmu` driven during N+1, `resp_valid_o` at N+2. The next accept is possible at N+2.
- **Throughput:** back-to-back hits give one response per cycle.
- **Reset during MISS:** returns to IDLE with no response and no install.
- **Flush in the same cycle as a hit:** the access is forced to miss, so the response comes from the `mmu` at N+2 and is not installed.

## Configuration
- `MICRO_TLB_PERF_EN` defined: adds outputs `perf_hit_cnt_o` [31:0] and `perf_miss_cnt_o` [31:0].
  - Each counts accepted requests that hit or miss respectively.
  - Both wrap at 2^32, reset to 0, and are not cleared by flush.
- `MICRO_TLB_PERF_EN` undefined: those ports and counters do not exist. Functional behaviour is identical.

## Test plan
- **Cold miss then hit:** vaddr 0x1C00_0040, `mmu` returns paddr 0x0000_0040, mat 1, found 1 -> response at N+2 with `resp_hit_o` = 0. A repeat to 0x1C00_0FFC -> response at +1 with paddr 0x0000_0FFC, `resp_hit_o` = 1.
- **Fill and replace with ENTRY_NUM 4:**
  - misses on pages 0x1000..0x4000 fill entries 0..3, pointer stays 0
  - page 0x5000 evicts entry 0, pointer becomes 1
  - page 0x1000 then misses again
- **Flush:**
  - `flush_i` pulse, then the previously hit page -> miss, `mmu` consulted
  - `flush_i` during MISS -> result returned, then the same page misses again
- **Flush concurrent with hit-accept:** the response arrives at N+2 from the `mmu`, `resp_hit_o` = 0.
- **Fault caching:** `mmu_found_i` = 0 on page 0x8000_0000 -> response found 0. A repeat hits with found 0, v 0.
- **Reset asserted during MISS:**
  - no `resp_valid_o`
  - all entries invalid
  - `req_ready_o` = 1 the cycle after reset release
  - with `MICRO_TLB_PERF_EN`, both counters read 0
